tl_ul_a_arbiter: RTL and testbench
==================================

# tl_ul_a_arbiter

Two-master TileLink-UL arbiter that shares one slave port on the E21 peripheral path. It arbitrates A-channel messages round-robin and holds the grant for the full length of multi-beat Put bursts. It tags each forwarded source ID with the master index and routes D-channel responses back by that tag. It also enforces a global cap on outstanding transactions so the downstream TileLink monitor never sees source-ID reuse.

## Interface
Parameters:
- ADDR_W, 32, A-channel address width
- DATA_W, 32, data width; BEAT_LG = log2(DATA_W/8)
- SIZE_W, 3, size field width
- SRC_W, 4, per-master source width; the slave-side source is SRC_W+1 bits
- MAX_INFLIGHT, 4, maximum outstanding transactions, counting both masters together

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- aN_valid / aN_ready  in / out  1  master N A handshake (N = 0, 1)
- aN_opcode  in  3  TL-UL opcode (0 PutFull, 1 PutPartial, 4 Get)
- aN_size  in  SIZE_W  log2 bytes
- aN_source  in  SRC_W  source ID
- aN_address  in  ADDR_W
- aN_mask / aN_data  in  DATA_W/8 / DATA_W
- a_valid / a_ready  out / in  1  slave A handshake
- a_opcode, a_size, a_address, a_mask, a_data  out  widths as above; muxed from the granted master
- a_source  out  SRC_W+1  {master index, aN_source}
- d_valid / d_ready  in / out  1  slave D handshake
- d_opcode  in  3; d_size  in  SIZE_W; d_source  in  SRC_W+1; d_denied  in  1; d_data  in  DATA_W
- dN_valid / dN_ready  out / in  1  master N D handshake
- dN_opcode, dN_size, dN_denied, dN_data  out; dN_source  out  SRC_W  (d_source[SRC_W-1:0])
- inflight  out  $clog2(MAX_INFLIGHT+1)  current outstanding count, for debug

## Operation
- Beats per A message: beats = 2^(size-BEAT_LG) when the opcode is a Put and size > BEAT_LG; otherwise 1. The same rule applies on D with opcode 1 (AccessAckData). A Get request is always 1 beat.
- FSM states are IDLE and BURST.
- IDLE:
  - If exactly one master is valid, it is selected.
  - If both are valid, the master != last_grant is selected.
  - The selected master's fields drive slave A. a_valid = sel_valid & ~cap_full. aSel_ready = a_ready & ~cap_full. The other master's ready is 0.
  - On fire: last_grant <= sel and inflight increments.
  - If beats > 1: owner <= sel, beats_left <= beats-1, go to BURST.
- BURST:
  - Only the owner is connected. cap_full is ignored because the transaction is already counted.
  - The other master's ready = 0.
  - Each fire decrements beats_left. At 1 → 0, return to IDLE.
  - Owner fields pass through per beat. The arbiter does not check that opcode, size, source or address stay stable; the monitor checks that.
- cap_full = (inflight == MAX_INFLIGHT), using the registered count. There is no same-cycle bypass from a D completion.
- D routing:
  - The target is d_source[SRC_W]. dT_valid = d_valid, d_ready = dT_ready, and the non-target dN_valid = 0.
  - A D beat counter d_beats_left loads on the first beat of each response.
  - The last D beat fire decrements inflight.
  - A and D events in the same cycle net to zero (hold).
- inflight never exceeds MAX_INFLIGHT and never underflows. A D last-beat with inflight == 0 is dropped from the count; the slave still gets its handshake.

## Timing
- Reset values: FSM = IDLE, last_grant = 1 (master 0 wins the first tie), owner = 0, beats_left = 0, d_beats_left = 0, inflight = 0.
- With reset held, all valids and readies out are 0: a_valid, aN_ready, dN_valid, d_ready.
- The A path is combinational from master to slave, with zero-cycle latency and no registers in the data path. The D path is also combinational, with zero latency.
- Grant changes take effect only at a clock edge following a fire. A selection shown in IDLE without a fire may change next cycle. The arbiter never deasserts a_valid while the slave is stalled, except when the selected master drops valid (master protocol error, not masked).
- Burst lock begins the cycle after the first-beat fire and ends the cycle after the last-beat fire. A new arbitration can fire on the cycle immediately after the last beat.
- Asserting reset_n low mid-burst or mid-response clears all state immediately. In-flight transactions are abandoned, and the next D beats after reset are routed by source but not counted.
- A fire is valid & ready at a rising edge of clock.

## Test plan
- Both masters hold single-beat Gets (a0_source = 3, a1_source = 5), a_ready = 1 → the first grant goes to master 0 with a_source = 0x03, the second to master 1 with a_source = 0x15; grants strictly alternate across 8 requests.
- Master 1 sends PutFull with size = 4 (4 beats, DATA_W = 32) while master 0 is valid throughout; a_ready toggles 1/0 → a1_ready stays 0 until all 4 beats fire, a0_ready = 0 during the burst, and master 0 is granted the cycle after the 4th beat.
- Issue 4 Gets with no D responses, then a 5th Get → a_valid = 0 and inflight = 4. One AccessAck with d_source = 0x12 → d1_valid = 1, d1_source = 2, and the 5th Get fires the following cycle.
- A 4-beat AccessAckData to d_source = 0x07 with d0_ready stalling 2 cycles → d_ready mirrors d0_ready, d1_valid never asserts, and inflight decrements only after the 4th beat fires.
- In the same cycle, an A first-beat fire and a D last-beat fire with inflight = 2 → inflight stays 2.
- Pull reset_n low after beat 2 of a 4-beat Put → a_valid drops the same cycle, inflight = 0, and after release the FSM is IDLE with master 0 winning the tie.

Source files
------------

// File: rtl/tl_ul_a_arbiter.sv
// Two-master TileLink-UL arbiter in front of a single slave port.
//
// Purpose:
//   - Round-robin arbitration of A-channel messages, with the grant held for every beat of a
//     multi-beat Put burst.
//   - The master index is prepended to the forwarded source ID. D-channel responses are
//     routed back to the master named by that tag bit.
//   - A global cap on outstanding transactions (MAX_INFLIGHT) stops new requests from issuing
//     while the cap is reached, so downstream never sees a source ID reused.
//
// Ports:
//   clock, reset_n           : clock (rising edge) and asynchronous active-low reset
//   aN_*  (N = 0, 1)         : master A channels (valid/ready handshake plus request fields)
//   a_*                      : slave A channel; fields come from the granted master
//   d_*                      : slave D channel (response from the slave)
//   dN_*  (N = 0, 1)         : master D channels; d_source[SRC_W] selects the target master
//   inflight                 : current outstanding-transaction count, for debug
module tl_ul_a_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned SIZE_W       = 3,
    parameter int unsigned SRC_W        = 4,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                              clock,
    input  logic                              reset_n,
    // master 0 A
    input  logic                              a0_valid,
    output logic                              a0_ready,
    input  logic [2:0]                        a0_opcode,
    input  logic [SIZE_W-1:0]                 a0_size,
    input  logic [SRC_W-1:0]                  a0_source,
    input  logic [ADDR_W-1:0]                 a0_address,
    input  logic [DATA_W/8-1:0]               a0_mask,
    input  logic [DATA_W-1:0]                 a0_data,
    // master 1 A
    input  logic                              a1_valid,
    output logic                              a1_ready,
    input  logic [2:0]                        a1_opcode,
    input  logic [SIZE_W-1:0]                 a1_size,
    input  logic [SRC_W-1:0]                  a1_source,
    input  logic [ADDR_W-1:0]                 a1_address,
    input  logic [DATA_W/8-1:0]               a1_mask,
    input  logic [DATA_W-1:0]                 a1_data,
    // slave A
    output logic                              a_valid,
    input  logic                              a_ready,
    output logic [2:0]                        a_opcode,
    output logic [SIZE_W-1:0]                 a_size,
    output logic [SRC_W:0]                    a_source,
    output logic [ADDR_W-1:0]                 a_address,
    output logic [DATA_W/8-1:0]               a_mask,
    output logic [DATA_W-1:0]                 a_data,
    // slave D
    input  logic                              d_valid,
    output logic                              d_ready,
    input  logic [2:0]                        d_opcode,
    input  logic [SIZE_W-1:0]                 d_size,
    input  logic [SRC_W:0]                    d_source,
    input  logic                              d_denied,
    input  logic [DATA_W-1:0]                 d_data,
    // master 0 D
    output logic                              d0_valid,
    input  logic                              d0_ready,
    output logic [2:0]                        d0_opcode,
    output logic [SIZE_W-1:0]                 d0_size,
    output logic [SRC_W-1:0]                  d0_source,
    output logic                              d0_denied,
    output logic [DATA_W-1:0]                 d0_data,
    // master 1 D
    output logic                              d1_valid,
    input  logic                              d1_ready,
    output logic [2:0]                        d1_opcode,
    output logic [SIZE_W-1:0]                 d1_size,
    output logic [SRC_W-1:0]                  d1_source,
    output logic                              d1_denied,
    output logic [DATA_W-1:0]                 d1_data,
    // debug
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight
);

    localparam int unsigned BEAT_LG = $clog2(DATA_W / 8);
    // Wide enough for the largest burst a SIZE_W-bit size field can describe.
    localparam int unsigned BCNT_W  = 2 ** SIZE_W;
    localparam int unsigned CNT_W   = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic [BCNT_W-1:0]   beats_left_q, beats_left_d;
    logic [BCNT_W-1:0]   d_beats_left_q, d_beats_left_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;

    // Number of beats in a message: only data-carrying messages larger than one bus word
    // span more than one beat.
    function automatic logic [BCNT_W-1:0] calc_beats(input logic has_data,
                                                     input logic [SIZE_W-1:0] size);
        logic [BCNT_W-1:0] b;
        b = BCNT_W'(1);
        if (has_data && (int'(size) > int'(BEAT_LG))) begin
            b = BCNT_W'(1) << (int'(size) - int'(BEAT_LG));
        end
        return b;
    endfunction

    // ------------------------------------------------------------------ A channel
    logic              sel;
    logic              sel_valid;
    logic              sel_ready;
    logic              cap_full;
    logic              a_open;
    logic              a_fire;
    logic              a_first_fire;
    logic              a_is_put;
    logic [BCNT_W-1:0] a_beats;

    assign cap_full = (inflight_q == CNT_W'(MAX_INFLIGHT));

    always_comb begin
        sel = ~last_grant_q;
        if (state_q == StBurst) begin
            sel = owner_q;
        end else if (a0_valid && !a1_valid) begin
            sel = 1'b0;
        end else if (a1_valid && !a0_valid) begin
            sel = 1'b1;
        end
    end

    // A burst in progress is already counted, so the cap only gates new messages.
    assign a_open    = (state_q == StBurst) || !cap_full;
    assign sel_valid = sel ? a1_valid : a0_valid;
    // Reset gating keeps every handshake output low while reset is held.
    assign a_valid   = reset_n & sel_valid & a_open;
    assign sel_ready = reset_n & a_ready & a_open;
    assign a0_ready  = sel_ready & ~sel;
    assign a1_ready  = sel_ready & sel;

    assign a_opcode  = sel ? a1_opcode  : a0_opcode;
    assign a_size    = sel ? a1_size    : a0_size;
    assign a_source  = {sel, (sel ? a1_source : a0_source)};
    assign a_address = sel ? a1_address : a0_address;
    assign a_mask    = sel ? a1_mask    : a0_mask;
    assign a_data    = sel ? a1_data    : a0_data;

    assign a_fire       = a_valid & a_ready;
    assign a_first_fire = a_fire & (state_q == StIdle);
    assign a_is_put     = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    assign a_beats      = calc_beats(a_is_put, a_size);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        beats_left_d = beats_left_q;
        unique case (state_q)
            StIdle: begin
                if (a_fire) begin
                    last_grant_d = sel;
                    if (a_beats > BCNT_W'(1)) begin
                        owner_d      = sel;
                        beats_left_d = a_beats - BCNT_W'(1);
                        state_d      = StBurst;
                    end
                end
            end
            StBurst: begin
                if (a_fire) begin
                    beats_left_d = beats_left_q - BCNT_W'(1);
                    if (beats_left_q == BCNT_W'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------ D channel
    logic              d_tgt;
    logic              d_fire;
    logic              d_first;
    logic              d_last;
    logic              d_dec;
    logic [BCNT_W-1:0] d_beats;

    assign d_tgt     = d_source[SRC_W];
    assign d0_valid  = reset_n & d_valid & ~d_tgt;
    assign d1_valid  = reset_n & d_valid & d_tgt;
    assign d_ready   = reset_n & (d_tgt ? d1_ready : d0_ready);

    assign d0_opcode = d_opcode;
    assign d0_size   = d_size;
    assign d0_source = d_source[SRC_W-1:0];
    assign d0_denied = d_denied;
    assign d0_data   = d_data;
    assign d1_opcode = d_opcode;
    assign d1_size   = d_size;
    assign d1_source = d_source[SRC_W-1:0];
    assign d1_denied = d_denied;
    assign d1_data   = d_data;

    assign d_fire  = d_valid & d_ready;
    // A zero beat counter means the next D beat starts a new response.
    assign d_first = (d_beats_left_q == '0);
    assign d_beats = calc_beats(d_opcode == 3'd1, d_size);
    assign d_last  = d_first ? (d_beats == BCNT_W'(1)) : (d_beats_left_q == BCNT_W'(1));
    // Completions with nothing outstanding (e.g. after a reset) are not counted.
    assign d_dec   = d_fire & d_last & (inflight_q != '0);

    always_comb begin
        d_beats_left_d = d_beats_left_q;
        if (d_fire) begin
            d_beats_left_d = d_first ? (d_beats - BCNT_W'(1))
                                     : (d_beats_left_q - BCNT_W'(1));
        end
    end

    // A new message never fires while the cap is reached, so the count cannot overflow.
    always_comb begin
        inflight_d = inflight_q;
        unique case ({a_first_fire, d_dec})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    assign inflight = inflight_q;

    // ------------------------------------------------------------------ state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            last_grant_q   <= 1'b1;
            owner_q        <= 1'b0;
            beats_left_q   <= '0;
            d_beats_left_q <= '0;
            inflight_q     <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            owner_q        <= owner_d;
            beats_left_q   <= beats_left_d;
            d_beats_left_q <= d_beats_left_d;
            inflight_q     <= inflight_d;
        end
    end

endmodule

// File: tb/tb_tl_ul_a_arbiter.sv
// Scoreboard bench for tl_ul_a_arbiter: directed stimulus pushes the expected slave-A and
// master-D beats; a negedge monitor pops and compares them whenever a handshake is about to
// complete.
module tb_tl_ul_a_arbiter;

    logic        clock;
    logic        reset_n;
    logic        a0_valid, a0_ready, a1_valid, a1_ready;
    logic [2:0]  a0_opcode, a1_opcode, a_opcode, d_opcode, d0_opcode, d1_opcode;
    logic [2:0]  a0_size, a1_size, a_size, d_size, d0_size, d1_size;
    logic [3:0]  a0_source, a1_source, d0_source, d1_source;
    logic [31:0] a0_address, a1_address, a_address;
    logic [3:0]  a0_mask, a1_mask, a_mask;
    logic [31:0] a0_data, a1_data, a_data, d_data, d0_data, d1_data;
    logic        a_valid, a_ready, d_valid, d_ready;
    logic [4:0]  a_source, d_source;
    logic        d_denied, d0_denied, d1_denied;
    logic        d0_valid, d0_ready, d1_valid, d1_ready;
    logic [2:0]  inflight;

    tl_ul_a_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .a0_valid(a0_valid), .a0_ready(a0_ready), .a0_opcode(a0_opcode), .a0_size(a0_size),
        .a0_source(a0_source), .a0_address(a0_address), .a0_mask(a0_mask), .a0_data(a0_data),
        .a1_valid(a1_valid), .a1_ready(a1_ready), .a1_opcode(a1_opcode), .a1_size(a1_size),
        .a1_source(a1_source), .a1_address(a1_address), .a1_mask(a1_mask), .a1_data(a1_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
        .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
        .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
        .d0_valid(d0_valid), .d0_ready(d0_ready), .d0_opcode(d0_opcode), .d0_size(d0_size),
        .d0_source(d0_source), .d0_denied(d0_denied), .d0_data(d0_data),
        .d1_valid(d1_valid), .d1_ready(d1_ready), .d1_opcode(d1_opcode), .d1_size(d1_size),
        .d1_source(d1_source), .d1_denied(d1_denied), .d1_data(d1_data),
        .inflight(inflight)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  src;
        logic [31:0] addr;
        logic [31:0] data;
    } a_exp_t;

    typedef struct packed {
        logic        port;
        logic [3:0]  src;
        logic [31:0] data;
    } d_exp_t;

    a_exp_t a_q[$];
    d_exp_t d_q[$];
    int     checks   = 0;
    int     failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: at the negedge a valid&ready pair is a handshake that completes next edge.
    always @(negedge clock) begin
        a_exp_t ea;
        d_exp_t ed;
        if (a_valid && a_ready) begin
            if (a_q.size() == 0) begin
                chk("a_unexpected_beat", {59'd0, a_source}, 64'hffff);
            end else begin
                ea = a_q.pop_front();
                chk("sb_a_source", {59'd0, a_source}, {59'd0, ea.src});
                chk("sb_a_address", {32'd0, a_address}, {32'd0, ea.addr});
                chk("sb_a_data", {32'd0, a_data}, {32'd0, ea.data});
            end
        end
        if ((d0_valid && d0_ready) || (d1_valid && d1_ready)) begin
            if (d_q.size() == 0) begin
                chk("d_unexpected_beat", {59'd0, d_source}, 64'hffff);
            end else begin
                ed = d_q.pop_front();
                chk("sb_d_port", {63'd0, d1_valid}, {63'd0, ed.port});
                chk("sb_d_source", {60'd0, (d1_valid ? d1_source : d0_source)},
                    {60'd0, ed.src});
                chk("sb_d_data", {32'd0, (d1_valid ? d1_data : d0_data)}, {32'd0, ed.data});
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic neg();
        @(negedge clock);
    endtask

    task automatic push_a(input logic [4:0] src, input logic [31:0] addr, input logic [31:0] dat);
        a_q.push_back('{src: src, addr: addr, data: dat});
    endtask

    task automatic m_get(input int m, input logic [3:0] src, input logic [31:0] addr);
        if (m == 0) begin
            a0_opcode = 3'd4; a0_size = 3'd2; a0_source = src; a0_address = addr;
            a0_mask = 4'hf; a0_data = '0; a0_valid = 1'b1;
        end else begin
            a1_opcode = 3'd4; a1_size = 3'd2; a1_source = src; a1_address = addr;
            a1_mask = 4'hf; a1_data = '0; a1_valid = 1'b1;
        end
    endtask

    task automatic m1_put(input logic [3:0] src, input logic [31:0] addr);
        a1_opcode = 3'd0; a1_size = 3'd4; a1_source = src; a1_address = addr;
        a1_mask = 4'hf; a1_valid = 1'b1;
    endtask

    // One single-beat AccessAck to the given tagged source.
    task automatic d_resp(input logic [4:0] src);
        d_valid = 1'b1; d_opcode = 3'd0; d_size = 3'd2; d_source = src; d_data = '0;
        d0_ready = 1'b1; d1_ready = 1'b1;
        d_q.push_back('{port: src[4], src: src[3:0], data: 32'd0});
        neg();
        cyc();
        d_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beat;
        int m0f;
        bit ar;
        bit after_last;
        bit f0;
        bit f1;
        int dbeat;

        // Reset held with requests pending: every handshake output must stay low.
        reset_n = 1'b0;
        a0_valid = 0; a1_valid = 0; a_ready = 1; d_valid = 1; d_opcode = 0; d_size = 2;
        d_source = 5'h00; d_denied = 0; d_data = 0; d0_ready = 1; d1_ready = 1;
        m_get(0, 4'd3, 32'h1000);
        m_get(1, 4'd5, 32'h2000);
        #12;
        chk("rst_a_valid", {63'd0, a_valid}, 64'd0);
        chk("rst_a0_ready", {63'd0, a0_ready}, 64'd0);
        chk("rst_a1_ready", {63'd0, a1_ready}, 64'd0);
        chk("rst_d0_valid", {63'd0, d0_valid}, 64'd0);
        chk("rst_d_ready", {63'd0, d_ready}, 64'd0);
        chk("rst_inflight", {61'd0, inflight}, 64'd0);
        a0_valid = 0; a1_valid = 0; d_valid = 0;
        reset_n = 1'b1;
        cyc();

        // Alternating Gets up to the cap.
        m_get(0, 4'd3, 32'h1000);
        m_get(1, 4'd5, 32'h2000);
        push_a(5'h03, 32'h1000, 0); push_a(5'h15, 32'h2000, 0);
        push_a(5'h03, 32'h1000, 0); push_a(5'h15, 32'h2000, 0);
        repeat (4) begin neg(); cyc(); end
        neg();
        chk("cap_a_valid", {63'd0, a_valid}, 64'd0);
        chk("cap_inflight", {61'd0, inflight}, 64'd4);
        chk("cap_a0_ready", {63'd0, a0_ready}, 64'd0);
        cyc();

        // One AccessAck to 0x12 frees a slot; the cap is released only on the next cycle.
        d_valid = 1; d_opcode = 0; d_size = 2; d_source = 5'h12; d_data = 0;
        d0_ready = 0; d1_ready = 1;
        d_q.push_back('{port: 1'b1, src: 4'd2, data: 32'd0});
        neg();
        chk("dack_d1_valid", {63'd0, d1_valid}, 64'd1);
        chk("dack_d1_source", {60'd0, d1_source}, 64'd2);
        chk("dack_d0_valid", {63'd0, d0_valid}, 64'd0);
        chk("dack_d_ready", {63'd0, d_ready}, 64'd1);
        chk("dack_no_bypass", {63'd0, a_valid}, 64'd0);
        cyc();
        d_valid = 0;
        push_a(5'h03, 32'h1000, 0);
        neg();
        chk("fifth_inflight", {61'd0, inflight}, 64'd3);
        chk("fifth_a_valid", {63'd0, a_valid}, 64'd1);
        cyc();
        a0_valid = 0; a1_valid = 0;
        neg();
        chk("refill_inflight", {61'd0, inflight}, 64'd4);
        cyc();
        d_resp(5'h03); d_resp(5'h15); d_resp(5'h03); d_resp(5'h03);
        neg();
        chk("drain1_inflight", {61'd0, inflight}, 64'd0);
        cyc();

        // Remaining alternation: master 0 won last, so master 1 is next.
        m_get(0, 4'd3, 32'h1000);
        m_get(1, 4'd5, 32'h2000);
        push_a(5'h15, 32'h2000, 0); push_a(5'h03, 32'h1000, 0); push_a(5'h15, 32'h2000, 0);
        repeat (3) begin neg(); cyc(); end
        a0_valid = 0; a1_valid = 0;
        d_resp(5'h15); d_resp(5'h03); d_resp(5'h15);

        // 4-beat PutFull from master 1 with master 0 valid throughout, a_ready toggling.
        m_get(0, 4'd3, 32'h1000);
        m1_put(4'd7, 32'h3000);
        push_a(5'h03, 32'h1000, 0);
        for (int k = 0; k < 4; k++) push_a(5'h17, 32'h3000, 32'hB000_0000 + k);
        push_a(5'h03, 32'h1000, 0);
        push_a(5'h15, 32'h2000, 0);
        beat = 0; m0f = 0; ar = 1; after_last = 0;
        for (int c = 0; c < 40 && !(m0f == 2 && beat == 5); c++) begin
            a_ready = ar;
            if (beat < 4) a1_data = 32'hB000_0000 + beat;
            a1_valid = (beat < 5);
            neg();
            if (beat >= 1 && beat < 4) begin
                chk("burst_a0_ready", {63'd0, a0_ready}, 64'd0);
                chk("burst_a_source", {59'd0, a_source}, 64'h17);
                chk("burst_a_valid", {63'd0, a_valid}, 64'd1);
            end
            if (after_last) begin
                chk("post_burst_a_source", {59'd0, a_source}, 64'h03);
                chk("post_burst_a_valid", {63'd0, a_valid}, 64'd1);
                after_last = 0;
            end
            f1 = a1_valid && a1_ready;
            f0 = a0_valid && a0_ready;
            cyc();
            if (f1) begin
                beat++;
                if (beat == 4) begin
                    after_last = 1;
                    m_get(1, 4'd5, 32'h2000);
                end
            end
            if (f0) begin
                m0f++;
                if (m0f == 2) a0_valid = 0;
            end
            ar = ~ar;
        end
        a0_valid = 0; a1_valid = 0; a_ready = 1;
        chk("burst_seq_done", {32'd0, beat[15:0], m0f[15:0]}, {32'd0, 16'd5, 16'd2});
        d_resp(5'h03); d_resp(5'h17); d_resp(5'h03); d_resp(5'h15);
        neg();
        chk("drain2_inflight", {61'd0, inflight}, 64'd0);
        cyc();

        // 4-beat AccessAckData to 0x07 with master 0 stalling the first 2 cycles.
        m_get(0, 4'd7, 32'h4000);
        push_a(5'h07, 32'h4000, 0);
        neg(); cyc();
        a0_valid = 0;
        for (int k = 0; k < 4; k++) d_q.push_back('{port: 1'b0, src: 4'd7, data: 32'hD000_0000 + k});
        d_valid = 1; d_opcode = 3'd1; d_size = 3'd4; d_source = 5'h07; d1_ready = 1;
        dbeat = 0;
        for (int c = 0; c < 20 && dbeat < 4; c++) begin
            d_data = 32'hD000_0000 + dbeat;
            d0_ready = (c >= 2);
            neg();
            chk("dd_d_ready_mirror", {63'd0, d_ready}, {63'd0, (c >= 2)});
            chk("dd_d1_valid", {63'd0, d1_valid}, 64'd0);
            chk("dd_inflight_held", {61'd0, inflight}, 64'd1);
            f0 = d0_valid && d0_ready;
            cyc();
            if (f0) dbeat++;
        end
        d_valid = 0; d0_ready = 1;
        neg();
        chk("dd_beats", dbeat, 64'd4);
        chk("dd_inflight_done", {61'd0, inflight}, 64'd0);
        cyc();

        // Simultaneous A first-beat fire and D last-beat fire at inflight = 2.
        m_get(0, 4'd1, 32'h5000);
        m_get(1, 4'd2, 32'h6000);
        push_a(5'h12, 32'h6000, 0); push_a(5'h01, 32'h5000, 0);
        repeat (2) begin neg(); cyc(); end
        a1_valid = 0;
        push_a(5'h01, 32'h5000, 0);
        d_valid = 1; d_opcode = 0; d_size = 2; d_source = 5'h12; d_data = 0; d1_ready = 1;
        d_q.push_back('{port: 1'b1, src: 4'd2, data: 32'd0});
        neg();
        chk("net_pre_inflight", {61'd0, inflight}, 64'd2);
        cyc();
        a0_valid = 0; d_valid = 0;
        neg();
        chk("net_zero_inflight", {61'd0, inflight}, 64'd2);
        cyc();
        d_resp(5'h01); d_resp(5'h01);

        // Reset pulled mid-burst after 2 beats.
        m_get(0, 4'd3, 32'h1000);
        m1_put(4'd7, 32'h3000);
        a_ready = 1;
        push_a(5'h17, 32'h3000, 32'hF000_0000);
        push_a(5'h17, 32'h3000, 32'hF000_0001);
        for (int k = 0; k < 2; k++) begin
            a1_data = 32'hF000_0000 + k;
            neg();
            cyc();
        end
        a1_data = 32'hF000_0002;
        reset_n = 0;
        #1;
        chk("rst_mid_a_valid", {63'd0, a_valid}, 64'd0);
        chk("rst_mid_a1_ready", {63'd0, a1_ready}, 64'd0);
        chk("rst_mid_inflight", {61'd0, inflight}, 64'd0);
        a0_valid = 0; a1_valid = 0;
        cyc();
        reset_n = 1;
        // A stray completion after reset is routed but leaves the count at zero.
        d_resp(5'h15);
        neg();
        chk("rst_d_uncounted", {61'd0, inflight}, 64'd0);
        cyc();
        m_get(0, 4'd3, 32'h1000);
        m_get(1, 4'd5, 32'h2000);
        push_a(5'h03, 32'h1000, 0); push_a(5'h15, 32'h2000, 0);
        neg();
        chk("rst_tie_a_source", {59'd0, a_source}, 64'h03);
        cyc();
        neg();
        chk("rst_idle_a_source", {59'd0, a_source}, 64'h15);
        cyc();
        a0_valid = 0; a1_valid = 0;
        d_resp(5'h03); d_resp(5'h15);
        neg();
        chk("final_inflight", {61'd0, inflight}, 64'd0);
        chk("a_queue_empty", a_q.size(), 64'd0);
        chk("d_queue_empty", d_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
